// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the trace step sequencer and related trace checkers.
//   STEP_W / REGS_W    : trace step word and register-file widths
//   *_LSB              : field offsets inside a step word
//   err_e              : verdict error codes
//   state_e            : sequencer FSM states
package step_sequencer_pkg;
   localparam int STEP_W    = 560;
   localparam int REGS_W    = 320;
   localparam int INSTR_LSB = 0;
   localparam int REGS_LSB  = 96;
   localparam int HINT1_LSB = 416;
   localparam int HINT2_LSB = 488;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISMATCH = 2'd1,
      ERR_OVERFLOW = 2'd2,
      ERR_PROTO    = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FIRST, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_FAIL
   } state_e;
endpackage

// File: rtl/step_check_regs.sv
// Register-file equality comparator.
//   clk, rst   : clock / async active-high reset (used only when REG_OUT=1)
//   a, b       : register files to compare
//   mismatch   : combinational a != b
//   mismatch_q : registered mismatch when REG_OUT=1, else same as mismatch
module step_check_regs
   import step_sequencer_pkg::*;
#(
   parameter int W       = REGS_W,
   parameter bit REG_OUT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         mismatch,
   output logic         mismatch_q
);
   assign mismatch = (a != b);

   generate
      if (REG_OUT) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) mismatch_q <= 1'b0;
            else     mismatch_q <= mismatch;
         end
      end else begin : g_comb
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign mismatch_q     = mismatch;
      end
   endgenerate
endmodule

// File: rtl/step_sequencer.sv
// Trace step sequencer: takes step words from the trace loader, issues them one
// at a time to the fetch/execute datapath, and checks each returned post-state
// against the pre-state of the following step.
//   step_in_*     : step word stream from the loader (ready is a state decode)
//   issue_*       : current step towards the datapath
//   result_*      : datapath post-state, single-cycle pulse
//   step_count    : steps issued, saturating at MAX_STEPS
//   done/ok/err   : sticky verdict
module step_sequencer
   import step_sequencer_pkg::*;
#(
   parameter int MAX_STEPS = 1024,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_in_valid,
   output logic              step_in_ready,
   input  logic [STEP_W-1:0] step_in,
   input  logic              step_in_last,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [STEP_W-1:0] issue_step,
   input  logic              result_valid,
   input  logic [REGS_W-1:0] result_regs,
   output logic [CNT_W-1:0]  step_count,
   output logic              done,
   output logic              ok,
   output logic [1:0]        err_code
);
   state_e              state, state_nx;
   err_e                err_q, err_nx;
   logic [STEP_W-1:0]   step_q;
   logic                last_q;
   logic [REGS_W-1:0]   res_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                load, take, cap;
   logic                mismatch, unused_mismatch_q;
   logic                at_max;

   step_check_regs #(.W(REGS_W), .REG_OUT(1'b0)) u_chk (
      .clk        (clk),
      .rst        (rst),
      .a          (step_in[REGS_LSB +: REGS_W]),
      .b          (res_q),
      .mismatch   (mismatch),
      .mismatch_q (unused_mismatch_q)
   );

   assign at_max = (cnt_q == CNT_W'(MAX_STEPS));

   always_comb begin
      state_nx = state;
      err_nx   = err_q;
      load     = 1'b0;
      take     = 1'b0;
      cap      = 1'b0;
      case (state)
         S_IDLE:  state_nx = S_FIRST;
         S_FIRST: begin
            if (result_valid) begin
               state_nx = S_FAIL;
               err_nx   = ERR_PROTO;
            end else if (step_in_valid) begin
               load     = 1'b1;
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (result_valid) begin
               state_nx = S_FAIL;
               err_nx   = ERR_PROTO;
            end else if (issue_ready) begin
               take     = 1'b1;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (result_valid) begin
               cap      = 1'b1;
               state_nx = last_q ? S_DONE : S_NEXT;
            end
         end
         S_NEXT: begin
            if (result_valid) begin
               state_nx = S_FAIL;
               err_nx   = ERR_PROTO;
            end else if (step_in_valid) begin
               // a rejected word is still consumed (ready was high)
               if (mismatch) begin
                  state_nx = S_FAIL;
                  err_nx   = ERR_MISMATCH;
               end else if (at_max) begin
                  state_nx = S_FAIL;
                  err_nx   = ERR_OVERFLOW;
               end else begin
                  load     = 1'b1;
                  state_nx = S_ISSUE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         err_q  <= ERR_NONE;
         step_q <= '0;
         last_q <= 1'b0;
         res_q  <= '0;
         cnt_q  <= '0;
      end else begin
         state <= state_nx;
         err_q <= err_nx;
         if (load) begin
            step_q <= step_in;
            last_q <= step_in_last;
         end
         if (take && !at_max) cnt_q <= cnt_q + 1'b1;
         if (cap) res_q <= result_regs;
      end
   end

   // all outputs are decodes of registered state only
   assign step_in_ready = (state == S_FIRST) || (state == S_NEXT);
   assign issue_valid   = (state == S_ISSUE);
   assign issue_step    = step_q;
   assign step_count    = cnt_q;
   assign done          = (state == S_DONE) || (state == S_FAIL);
   assign ok            = (state == S_DONE);
   assign err_code      = (state == S_FAIL) ? err_q : ERR_NONE;
endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;
   import step_sequencer_pkg::*;

   localparam int MAXS  = 4;
   localparam int CNT_W = 16;

   logic              clk, rst;
   logic              step_in_valid, step_in_ready, step_in_last;
   logic [STEP_W-1:0] step_in, issue_step;
   logic              issue_valid, issue_ready;
   logic              result_valid;
   logic [REGS_W-1:0] result_regs;
   logic [CNT_W-1:0]  step_count;
   logic              done, ok;
   logic [1:0]        err_code;

   step_sequencer #(.MAX_STEPS(MAXS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .step_in_valid(step_in_valid), .step_in_ready(step_in_ready),
      .step_in(step_in), .step_in_last(step_in_last),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_step(issue_step),
      .result_valid(result_valid), .result_regs(result_regs),
      .step_count(step_count), .done(done), .ok(ok), .err_code(err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [STEP_W-1:0] act, input logic [STEP_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- transaction-level reference model ----------------
   localparam int P_IDLE = 0, P_ACC = 1, P_ISS = 2, P_WAIT = 3, P_END = 4;
   int                m_phase = P_IDLE;
   bit                m_first = 1'b1, m_last = 1'b0, m_ok = 1'b0;
   logic [1:0]        m_err = 2'd0;
   logic [REGS_W-1:0] m_exp = '0;
   logic [STEP_W-1:0] m_step = '0;
   int                m_count = 0;

   task automatic m_finish(input bit good, input logic [1:0] e);
      m_phase = P_END; m_ok = good; m_err = e;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = P_IDLE; m_first = 1'b1; m_last = 1'b0; m_ok = 1'b0;
         m_err = 2'd0; m_exp = '0; m_step = '0; m_count = 0;
      end else begin
         case (m_phase)
            P_IDLE: m_phase = P_ACC;
            P_ACC: begin
               if (result_valid) m_finish(1'b0, 2'd3);
               else if (step_in_valid) begin
                  if (!m_first && step_in[415:96] != m_exp) m_finish(1'b0, 2'd1);
                  else if (!m_first && m_count == MAXS) m_finish(1'b0, 2'd2);
                  else begin
                     m_step = step_in; m_last = step_in_last;
                     m_first = 1'b0; m_phase = P_ISS;
                  end
               end
            end
            P_ISS: begin
               if (result_valid) m_finish(1'b0, 2'd3);
               else if (issue_ready) begin
                  if (m_count < MAXS) m_count++;
                  m_phase = P_WAIT;
               end
            end
            P_WAIT: begin
               if (result_valid) begin
                  m_exp = result_regs;
                  if (m_last) m_finish(1'b1, 2'd0);
                  else m_phase = P_ACC;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("ready", step_in_ready, (m_phase == P_ACC));
      chk("issue_valid", issue_valid, (m_phase == P_ISS));
      chk("issue_step", issue_step, m_step);
      chk("step_count", step_count, m_count);
      chk("done", done, (m_phase == P_END));
      chk("ok", ok, (m_phase == P_END) && m_ok);
      chk("err_code", err_code, (m_phase == P_END) ? m_err : 2'd0);
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [REGS_W-1:0] regs_of(input int n, input logic [31:0] eip);
      return {{9{32'hC0DE_0000 | 32'(n)}}, eip};
   endfunction

   function automatic logic [STEP_W-1:0] mk(input int n, input logic [REGS_W-1:0] r);
      return {72'h2222_0000 + 72'(n), 72'h1111_0000 + 72'(n), r, 96'hABCD_0000 + 96'(n)};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send(input logic [STEP_W-1:0] w, input bit last);
      step_in_valid = 1'b1; step_in = w; step_in_last = last;
      for (int i = 0; i < 20; i++) begin
         if (step_in_ready) begin
            @(posedge clk); #1;
            step_in_valid = 1'b0; step_in_last = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      step_in_valid = 1'b0;
      chk("send accepted", step_in_ready, 1'b1);
   endtask

   task automatic dp(input int delay, input logic [REGS_W-1:0] res);
      for (int i = 0; i < 20 && !issue_valid; i++) begin
         @(posedge clk); #1;
      end
      if (!issue_valid) begin
         chk("issue_valid seen", issue_valid, 1'b1);
         return;
      end
      repeat (delay) begin
         @(posedge clk); #1;
      end
      issue_ready = 1'b1;
      @(posedge clk); #1;
      issue_ready = 1'b0;
      result_valid = 1'b1; result_regs = res;
      @(posedge clk); #1;
      result_valid = 1'b0;
   endtask

   logic [REGS_W-1:0] res [0:5];
   logic [STEP_W-1:0] w0;

   initial begin
      rst = 1'b1; step_in_valid = 1'b0; step_in = '0; step_in_last = 1'b0;
      issue_ready = 1'b0; result_valid = 1'b0; result_regs = '0;
      for (int i = 0; i < 6; i++) res[i] = regs_of(i + 1, 32'h1004 + 32'(4 * i));
      repeat (2) @(posedge clk);
      #1;
      chk("reset done", done, 1'b0);
      chk("reset ready", step_in_ready, 1'b0);
      chk("reset issue_step", issue_step, '0);
      rst = 1'b0;

      // 1: consistent 3-step trace
      w0 = mk(0, regs_of(0, 32'h1000));
      send(w0, 1'b0);
      chk("t1 issue_valid after accept", issue_valid, 1'b1);
      chk("t1 issue_step", issue_step, w0);
      dp(0, res[0]);
      chk("t1 ready after result", step_in_ready, 1'b1);
      send(mk(1, res[0]), 1'b0);
      dp(0, res[1]);
      send(mk(2, res[1]), 1'b1);
      dp(0, res[2]);
      chk("t1 done", done, 1'b1);
      chk("t1 ok", ok, 1'b1);
      chk("t1 err", err_code, 2'd0);
      chk("t1 count", step_count, 16'd3);

      // 2: eip mismatch on step 2 (0x1000 vs 0x1004)
      do_reset();
      send(w0, 1'b0);
      dp(0, res[0]);
      send(mk(1, regs_of(1, 32'h1000)), 1'b0);
      chk("t2 done", done, 1'b1);
      chk("t2 ok", ok, 1'b0);
      chk("t2 err", err_code, 2'd1);
      chk("t2 count", step_count, 16'd1);
      chk("t2 step2 not issued", issue_step, w0);

      // 3: overflow with MAX_STEPS=4
      do_reset();
      send(w0, 1'b0);
      dp(0, res[0]);
      for (int i = 1; i < 5; i++) begin
         send(mk(i, res[i-1]), 1'b0);
         if (i < 4) dp(0, res[i]);
      end
      chk("t3 done", done, 1'b1);
      chk("t3 err", err_code, 2'd2);
      chk("t3 count", step_count, 16'd4);

      // 4: result_valid while issuing
      do_reset();
      send(w0, 1'b0);
      @(posedge clk); #1;
      chk("t4 issue_valid", issue_valid, 1'b1);
      result_valid = 1'b1;
      @(posedge clk); #1;
      result_valid = 1'b0;
      chk("t4 done", done, 1'b1);
      chk("t4 err", err_code, 2'd3);
      chk("t4 count", step_count, 16'd0);

      // 5: datapath stall of 5 cycles
      do_reset();
      send(w0, 1'b1);
      dp(5, res[0]);
      chk("t5 count", step_count, 16'd1);
      chk("t5 ok", ok, 1'b1);

      // 6: async reset while waiting for a result
      do_reset();
      send(w0, 1'b0);
      issue_ready = 1'b1;
      @(posedge clk); #1;
      issue_ready = 1'b0;
      chk("t6 count before rst", step_count, 16'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6 async count", step_count, 16'd0);
      chk("t6 async issue_step", issue_step, '0);
      chk("t6 async flags", {step_in_ready, issue_valid, done, ok, err_code}, 6'd0);
      @(posedge clk); #1 rst = 1'b0;
      send(mk(9, regs_of(9, 32'h2000)), 1'b1);
      dp(0, res[0]);
      chk("t6 done", done, 1'b1);
      chk("t6 ok", ok, 1'b1);
      chk("t6 count", step_count, 16'd1);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
